// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: register index width, forward selects,
// MEM-stage handshake FSM states and pipeline shadow-register layouts.
package rv32_pkg;

    localparam int unsigned REG_IDX_W = 5;

    // Decoder wb_sel value that selects data-memory read data (loads).
    localparam logic [1:0] WB_SEL_LOAD = 2'b00;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
        logic     load;
        logic     mem_acc;
        fwd_sel_e fwd_a;
        fwd_sel_e fwd_b;
    } ex_shadow_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
        logic     mem_acc;
    } mem_shadow_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
    } wb_shadow_t;

    // A younger instruction's source operand matches an older in-flight writer.
    // Writes to x0 are discarded by the register file, so they never match.
    function automatic logic src_hit(
        input logic     valid,
        input logic     wen,
        input reg_idx_t rd,
        input logic     use_rs,
        input reg_idx_t rs
    );
        return valid & wen & (rd != '0) & use_rs & (rs == rd);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forward select for the instruction currently in ID, computed
// against the EX and MEM shadows (they will be in MEM and WB when it reaches EX).
module fwd_unit
    import rv32_pkg::*;
(
    input  logic                 use_rs,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 ex_valid,
    input  logic                 ex_wen,
    input  logic                 ex_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mem_valid,
    input  logic                 mem_wen,
    input  logic [REG_IDX_W-1:0] mem_rd,
    output logic [1:0]           fwd_sel
);

    // Nearer producer wins; a load in EX is handled by the load-use stall instead.
    always_comb begin
        fwd_sel = FWD_RF;
        if (src_hit(ex_valid, ex_wen, ex_rd, use_rs, rs)) begin
            fwd_sel = ex_load ? FWD_RF : FWD_MEM;
        end else if (src_hit(mem_valid, mem_wen, mem_rd, use_rs, rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: generates
// stall/flush/freeze controls, registered EX forward selects, stage valids and
// the data-memory request/timeout handshake.
module hazard_ctl
    import rv32_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_ready,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_wen,
    input  logic                 id_is_load,
    input  logic                 id_mem_acc,
    input  logic                 ex_pc_sel,
    input  logic                 dmem_ready,
    output logic                 stall_pc,
    output logic                 stall_ifid,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 freeze,
    output logic                 dmem_req,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 ex_valid,
    output logic                 mem_valid,
    output logic                 wb_valid,
    output logic                 mem_err
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ex_shadow_t  ex_q;
    mem_shadow_t mem_q;
    wb_shadow_t  wb_q;

    mem_state_e       mem_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             mem_err_q;

    logic       mem_stall;
    logic       load_use;
    logic       branch;
    logic       ld_hit_rs1;
    logic       ld_hit_rs2;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    // Raw hazard terms from the current shadows and ID-stage decode.
    always_comb begin
        mem_stall  = mem_q.valid & mem_q.mem_acc & ~dmem_ready;
        ld_hit_rs1 = id_use_rs1 & (id_rs1 == ex_q.rd);
        ld_hit_rs2 = id_use_rs2 & (id_rs2 == ex_q.rd);
        load_use   = id_valid & ex_q.valid & ex_q.load & (ex_q.rd != '0)
                   & (ld_hit_rs1 | ld_hit_rs2);
        branch     = ex_q.valid & ex_pc_sel;
    end

    // Prioritised stall/flush/freeze decode; a memory stall defers everything else.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        freeze     = 1'b0;
        if (mem_stall) begin
            freeze     = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else if (branch) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (!imem_ready) begin
            // PC holds until fetch data arrives; IF/ID takes a bubble meanwhile.
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
        end
    end

    fwd_unit u_fwd_a (
        .use_rs    (id_use_rs1),
        .rs        (id_rs1),
        .ex_valid  (ex_q.valid),
        .ex_wen    (ex_q.wen),
        .ex_load   (ex_q.load),
        .ex_rd     (ex_q.rd),
        .mem_valid (mem_q.valid),
        .mem_wen   (mem_q.wen),
        .mem_rd    (mem_q.rd),
        .fwd_sel   (fwd_a_nxt)
    );

    fwd_unit u_fwd_b (
        .use_rs    (id_use_rs2),
        .rs        (id_rs2),
        .ex_valid  (ex_q.valid),
        .ex_wen    (ex_q.wen),
        .ex_load   (ex_q.load),
        .ex_rd     (ex_q.rd),
        .mem_valid (mem_q.valid),
        .mem_wen   (mem_q.wen),
        .mem_rd    (mem_q.rd),
        .fwd_sel   (fwd_b_nxt)
    );

    // Shadow pipeline: advance every stage unless frozen; EX takes a bubble on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            if (flush_idex || !id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q.valid   <= 1'b1;
                ex_q.rd      <= id_rd;
                ex_q.wen     <= id_reg_wen;
                ex_q.load    <= id_is_load;
                ex_q.mem_acc <= id_mem_acc;
                ex_q.fwd_a   <= fwd_sel_e'(fwd_a_nxt);
                ex_q.fwd_b   <= fwd_sel_e'(fwd_b_nxt);
            end
            mem_q.valid   <= ex_q.valid;
            mem_q.rd      <= ex_q.rd;
            mem_q.wen     <= ex_q.wen;
            mem_q.mem_acc <= ex_q.mem_acc;
            wb_q.valid    <= mem_q.valid;
            wb_q.rd       <= mem_q.rd;
            wb_q.wen      <= mem_q.wen;
        end
    end

    always_comb wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_ONE;

    // MEM handshake FSM: counts dmem_ready-low cycles and flags a sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state <= MEM_IDLE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (mem_stall) begin
                        mem_state <= MEM_WAIT;
                        wait_cnt  <= CNT_ONE;
                        if (CNT_ONE == CNT_MAX) mem_err_q <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        mem_state <= MEM_IDLE;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == CNT_MAX) mem_err_q <= 1'b1;
                    end
                end
                default: begin
                    mem_state <= MEM_IDLE;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    assign dmem_req  = mem_q.valid & mem_q.mem_acc;
    assign fwd_a     = ex_q.fwd_a;
    assign fwd_b     = ex_q.fwd_b;
    assign ex_valid  = ex_q.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_q.valid;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl with MEM_TIMEOUT=4 and hand-computed expectations.
module tb_hazard_ctl;
    import rv32_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_ready;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_reg_wen, id_is_load, id_mem_acc;
    logic       ex_pc_sel;
    logic       dmem_ready;
    logic       stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, dmem_req;
    logic [1:0] fwd_a, fwd_b;
    logic       ex_valid, mem_valid, wb_valid, mem_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctl #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_ready (imem_ready),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_reg_wen (id_reg_wen),
        .id_is_load (id_is_load),
        .id_mem_acc (id_mem_acc),
        .ex_pc_sel  (ex_pc_sel),
        .dmem_ready (dmem_ready),
        .stall_pc   (stall_pc),
        .stall_ifid (stall_ifid),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .freeze     (freeze),
        .dmem_req   (dmem_req),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .ex_valid   (ex_valid),
        .mem_valid  (mem_valid),
        .wb_valid   (wb_valid),
        .mem_err    (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_none();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_reg_wen = 1'b0; id_is_load = 1'b0; id_mem_acc = 1'b0;
    endtask

    // ALU op: rd <- f(rs1, rs2); use flags select which sources are read.
    task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_wen = 1'b1; id_is_load = 1'b0; id_mem_acc = 1'b0;
    endtask

    task automatic id_lw(input logic [4:0] rd, input logic [4:0] rs1);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = '0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        id_rd = rd; id_reg_wen = 1'b1; id_is_load = 1'b1; id_mem_acc = 1'b1;
    endtask

    task automatic drain();
        id_none();
        ex_pc_sel = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
        repeat (3) tick();
    endtask

    // Packs {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze}.
    function automatic logic [31:0] ctl();
        return {27'd0, stall_pc, stall_ifid, flush_ifid, flush_idex, freeze};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_none();
        imem_ready = 1'b1; ex_pc_sel = 1'b0; dmem_ready = 1'b1;
        #12;
        check("rst_valids", {ex_valid, mem_valid, wb_valid}, 0);
        check("rst_fwd", {fwd_a, fwd_b}, 0);
        check("rst_err", mem_err, 0);
        check("rst_ctl", ctl(), 0);
        check("rst_req", dmem_req, 0);
        rst_n = 1'b1;
        tick();

        // Load-use: lw x5 ; add x6,x5,x1
        id_lw(5, 2);
        tick();
        id_alu(6, 5, 1, 1, 1);
        #1 check("lu_ctl", ctl(), 32'b11010);
        tick();
        check("lu_bubble", {ex_valid, mem_valid}, 32'b01);
        check("lu_req", dmem_req, 1);
        #1 check("lu_release_ctl", ctl(), 0);
        tick();
        check("lu_ex_valid", ex_valid, 1);
        check("lu_fwd", {fwd_a, fwd_b}, 32'b1000);
        check("lu_no_wait", 32'(dut.mem_state), 32'(MEM_IDLE));
        drain();

        // Back-to-back ALU: addi x3 ; sub x4,x3,x3
        id_alu(3, 0, 1, 0, 0);
        tick();
        id_alu(4, 3, 1, 3, 1);
        #1 check("b2b_ctl", ctl(), 0);
        tick();
        check("b2b_fwd", {fwd_a, fwd_b}, 32'b0101);
        drain();

        // addi x3 ; nop ; sub x4,x3,x3
        id_alu(3, 0, 1, 0, 0);
        tick();
        id_alu(0, 0, 1, 0, 0);
        tick();
        id_alu(4, 3, 1, 3, 1);
        #1 check("gap_ctl", ctl(), 0);
        tick();
        check("gap_fwd", {fwd_a, fwd_b}, 32'b1010);
        drain();

        // x0: addi x0 ; add x1,x0,x0, then lw x0 ; add x1,x0,x0
        id_alu(0, 0, 1, 0, 0);
        tick();
        id_alu(1, 0, 1, 0, 1);
        #1 check("x0_ctl", ctl(), 0);
        tick();
        check("x0_fwd", {fwd_a, fwd_b}, 0);
        id_lw(0, 0);
        tick();
        id_alu(1, 0, 1, 0, 1);
        #1 check("x0_load_ctl", ctl(), 0);
        tick();
        check("x0_load_fwd", {fwd_a, fwd_b}, 0);
        drain();

        // Taken branch in EX with a simultaneous load-use in ID
        id_lw(7, 1);
        tick();
        id_alu(8, 7, 1, 0, 1);
        ex_pc_sel = 1'b1;
        #1 check("br_ctl", ctl(), 32'b00110);
        tick();
        check("br_bubble", {ex_valid, mem_valid}, 32'b01);
        drain();

        // Fetch not ready
        imem_ready = 1'b0;
        #1 check("imem_ctl", ctl(), 32'b10100);
        drain();

        // Memory wait of 3 cycles with a branch pending behind the load
        id_lw(9, 1);
        tick();
        id_alu(10, 1, 1, 0, 0);
        tick();
        id_none();
        ex_pc_sel = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_ctl", ctl(), 32'b11001);
            check("mw_req", dmem_req, 1);
            tick();
            check("mw_state", 32'(dut.mem_state), 32'(MEM_WAIT));
        end
        dmem_ready = 1'b1;
        #1 check("mw_release_ctl", ctl(), 32'b00110);
        tick();
        check("mw_idle", 32'(dut.mem_state), 32'(MEM_IDLE));
        check("mw_valids", {ex_valid, mem_valid, wb_valid}, 32'b011);
        check("mw_no_err", mem_err, 0);
        drain();

        // Timeout: dmem_ready low 6 cycles, MEM_TIMEOUT=4
        id_lw(11, 1);
        tick();
        id_none();
        tick();
        dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            check("to_err", mem_err, (i >= 5) ? 1 : 0);
            tick();
        end
        check("to_err_final", mem_err, 1);
        dmem_ready = 1'b1;
        tick();
        check("to_err_sticky", mem_err, 1);
        check("to_idle", 32'(dut.mem_state), 32'(MEM_IDLE));
        drain();

        // Asynchronous reset in the middle of a wait
        id_lw(12, 1);
        tick();
        id_none();
        tick();
        dmem_ready = 1'b0;
        tick();
        tick();
        check("ar_waiting", 32'(dut.mem_state), 32'(MEM_WAIT));
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(dut.mem_state), 32'(MEM_IDLE));
        check("ar_err", mem_err, 0);
        check("ar_valids", {ex_valid, mem_valid, wb_valid}, 0);
        check("ar_fwd", {fwd_a, fwd_b}, 0);
        check("ar_ctl", ctl(), 0);
        check("ar_req", dmem_req, 0);
        dmem_ready = 1'b1;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
